// File: rtl/mux_key_table_if.sv
// Lookup-table bus: write port, clear, lookup request and result handshake.
//   master : drives writes, clr, in_valid/in_key/default_out, out_ready
//   slave  : drives in_ready and the registered result out_valid/out_data/out_hit/out_idx
interface mux_key_table_if #(
    parameter int KEY_LEN  = 7,
    parameter int DATA_LEN = 32,
    parameter int IDX_W    = 2
);
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [KEY_LEN-1:0]  wr_key;
    logic [DATA_LEN-1:0] wr_data;
    logic                wr_valid;
    logic                clr;
    logic                in_valid;
    logic                in_ready;
    logic [KEY_LEN-1:0]  in_key;
    logic [DATA_LEN-1:0] default_out;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] out_data;
    logic                out_hit;
    logic [IDX_W-1:0]    out_idx;

    modport master (
        output wr_en, wr_idx, wr_key, wr_data, wr_valid, clr,
        output in_valid, in_key, default_out, out_ready,
        input  in_ready, out_valid, out_data, out_hit, out_idx
    );

    modport slave (
        input  wr_en, wr_idx, wr_key, wr_data, wr_valid, clr,
        input  in_valid, in_key, default_out, out_ready,
        output in_ready, out_valid, out_data, out_hit, out_idx
    );
endinterface

// File: rtl/mux_key_table.sv
// Programmable key-match lookup table with a one-entry registered result.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mux_key_table_if.slave (write port, clear, lookup handshake, result)
// Lowest matching valid entry wins; a miss returns default_out (or zero when
// HAS_DEFAULT=0). Lookups read the table as it was before the same edge's
// write/clear.
module mux_key_table #(
    parameter int NR_KEY      = 4,
    parameter int KEY_LEN     = 7,
    parameter int DATA_LEN    = 32,
    parameter int HAS_DEFAULT = 1,
    localparam int IDX_W      = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
    input logic             clk,
    input logic             rst,
    mux_key_table_if.slave  bus
);

    logic                valid_q [NR_KEY];
    logic [KEY_LEN-1:0]  key_q   [NR_KEY];
    logic [DATA_LEN-1:0] data_q  [NR_KEY];

    logic                match_hit;
    logic [IDX_W-1:0]    match_idx;
    logic [DATA_LEN-1:0] match_data;

    logic                out_valid_q, out_valid_d;
    logic [DATA_LEN-1:0] out_data_q,  out_data_d;
    logic                out_hit_q,   out_hit_d;
    logic [IDX_W-1:0]    out_idx_q,   out_idx_d;

    logic                in_ready;
    logic                accept;

    // Clear has priority over a same-cycle write. Indices beyond NR_KEY match
    // no loop iteration and are therefore dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_KEY; i++) valid_q[i] <= 1'b0;
        end else if (bus.clr) begin
            for (int i = 0; i < NR_KEY; i++) valid_q[i] <= 1'b0;
        end else if (bus.wr_en) begin
            for (int i = 0; i < NR_KEY; i++) begin
                if (bus.wr_idx == IDX_W'(i)) valid_q[i] <= bus.wr_valid;
            end
        end
    end

    // Key/data need no reset: an entry is only observable through its valid bit.
    always_ff @(posedge clk) begin
        if (!rst && bus.wr_en) begin
            for (int i = 0; i < NR_KEY; i++) begin
                if (bus.wr_idx == IDX_W'(i)) begin
                    key_q[i]  <= bus.wr_key;
                    data_q[i] <= bus.wr_data;
                end
            end
        end
    end

    // Scan from the top so the lowest matching index is the last to assign.
    always_comb begin
        match_hit  = 1'b0;
        match_idx  = '0;
        match_data = '0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (valid_q[i] && (key_q[i] == bus.in_key)) begin
                match_hit  = 1'b1;
                match_idx  = IDX_W'(i);
                match_data = data_q[i];
            end
        end
    end

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_hit_d   = out_hit_q;
        out_idx_d   = out_idx_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_hit_d   = match_hit;
            out_idx_d   = match_idx;
            if (match_hit)
                out_data_d = match_data;
            else if (HAS_DEFAULT != 0)
                out_data_d = bus.default_out;
            else
                out_data_d = '0;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_hit_q   <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_hit_q   <= out_hit_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_hit   = out_hit_q;
    assign bus.out_idx   = out_idx_q;

endmodule

// File: tb/tb_mux_key_table.sv
module tb_mux_key_table;

    typedef struct packed {
        logic [31:0] data;
        logic        hit;
        logic [1:0]  idx;
    } res_t;

    logic clk;
    logic rst;

    logic        wr_en, wr_valid, clr, in_valid, out_ready;
    logic [1:0]  wr_idx;
    logic [6:0]  wr_key, in_key;
    logic [31:0] wr_data, default_out;

    int checks   = 0;
    int failures = 0;

    res_t q0[$];
    res_t q1[$];

    mux_key_table_if #(.KEY_LEN(7), .DATA_LEN(32), .IDX_W(2)) bif0 ();
    mux_key_table_if #(.KEY_LEN(7), .DATA_LEN(32), .IDX_W(2)) bif1 ();

    assign bif0.wr_en = wr_en;             assign bif1.wr_en = wr_en;
    assign bif0.wr_idx = wr_idx;           assign bif1.wr_idx = wr_idx;
    assign bif0.wr_key = wr_key;           assign bif1.wr_key = wr_key;
    assign bif0.wr_data = wr_data;         assign bif1.wr_data = wr_data;
    assign bif0.wr_valid = wr_valid;       assign bif1.wr_valid = wr_valid;
    assign bif0.clr = clr;                 assign bif1.clr = clr;
    assign bif0.in_valid = in_valid;       assign bif1.in_valid = in_valid;
    assign bif0.in_key = in_key;           assign bif1.in_key = in_key;
    assign bif0.default_out = default_out; assign bif1.default_out = default_out;
    assign bif0.out_ready = out_ready;     assign bif1.out_ready = out_ready;

    mux_key_table #(.NR_KEY(4), .KEY_LEN(7), .DATA_LEN(32), .HAS_DEFAULT(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bif0.slave)
    );

    mux_key_table #(.NR_KEY(4), .KEY_LEN(7), .DATA_LEN(32), .HAS_DEFAULT(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bif1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Miss results differ between the instances: default_out vs zero.
    task automatic push_exp(input logic [31:0] d, input logic h, input logic [1:0] ix);
        res_t r0;
        res_t r1;
        r0.data = d;             r0.hit = h; r0.idx = ix;
        r1.data = h ? d : 32'h0; r1.hit = h; r1.idx = ix;
        q0.push_back(r0);
        q1.push_back(r1);
    endtask

    // Scoreboard monitor: a result is consumed at the edge after a negedge
    // where out_valid && out_ready.
    always @(negedge clk) begin
        res_t r;
        if (bif0.out_valid && bif0.out_ready) begin
            if (q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL res0_unexpected actual=%h expected=none",
                         {bif0.out_data, bif0.out_hit, bif0.out_idx});
            end else begin
                r = q0.pop_front();
                chk("res0", {29'h0, bif0.out_data, bif0.out_hit, bif0.out_idx}, {29'h0, r});
            end
        end
        if (bif1.out_valid && bif1.out_ready) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL res1_unexpected actual=%h expected=none",
                         {bif1.out_data, bif1.out_hit, bif1.out_idx});
            end else begin
                r = q1.pop_front();
                chk("res1", {29'h0, bif1.out_data, bif1.out_hit, bif1.out_idx}, {29'h0, r});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] idx, input logic [6:0] key,
                         input logic [31:0] data, input logic v);
        wr_en = 1'b1; wr_idx = idx; wr_key = key; wr_data = data; wr_valid = v;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Issues one lookup; any wr_*/clr set by the caller lands on the accept edge.
    task automatic lookup(input logic [6:0] key, input logic [31:0] dflt,
                          input logic [31:0] ed, input logic eh, input logic [1:0] ei,
                          input bit push);
        int n;
        n = 0;
        in_valid = 1'b1; in_key = key; default_out = dflt;
        @(negedge clk);
        while (!bif0.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++; failures++;
            $display("FAIL lookup_timeout actual=in_ready_low expected=accept key=%h", key);
        end else if (push) begin
            push_exp(ed, eh, ei);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; wr_en = 1'b0; clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_valid = 1'b0; clr = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; wr_idx = '0; wr_key = '0; in_key = '0;
        wr_data = '0; default_out = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {63'h0, bif0.out_valid}, 64'h0);
        chk("rst_in_ready",  {63'h0, bif0.in_ready},  64'h1);
        chk("rst_out_data",  {32'h0, bif0.out_data},  64'h0);
        chk("rst_out_hit",   {63'h0, bif0.out_hit},   64'h0);
        chk("rst_out_idx",   {62'h0, bif0.out_idx},   64'h0);
        chk("rst_out_valid1", {63'h0, bif1.out_valid}, 64'h0);
        @(posedge clk); #1;

        // empty table miss
        lookup(7'h13, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2'd0, 1'b1);

        // priority
        write(2'd1, 7'h33, 32'h1111_1111, 1'b1);
        write(2'd3, 7'h33, 32'h3333_3333, 1'b1);
        lookup(7'h33, 32'h0, 32'h1111_1111, 1'b1, 2'd1, 1'b1);
        write(2'd1, 7'h33, 32'h1111_1111, 1'b0);
        lookup(7'h33, 32'h0, 32'h3333_3333, 1'b1, 2'd3, 1'b1);

        // read-before-write
        write(2'd0, 7'h6F, 32'hA, 1'b1);
        wr_en = 1'b1; wr_idx = 2'd0; wr_key = 7'h6F; wr_data = 32'hB; wr_valid = 1'b1;
        lookup(7'h6F, 32'h0, 32'hA, 1'b1, 2'd0, 1'b1);
        lookup(7'h6F, 32'h0, 32'hB, 1'b1, 2'd0, 1'b1);
        idle(2);

        // backpressure
        out_ready = 1'b0;
        lookup(7'h01, 32'h101, 32'h101, 1'b0, 2'd0, 1'b1);
        fork
            begin
                lookup(7'h02, 32'h102, 32'h102, 1'b0, 2'd0, 1'b1);
                lookup(7'h03, 32'h103, 32'h103, 1'b0, 2'd0, 1'b1);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", {63'h0, bif0.in_ready}, 64'h0);
                    chk("bp_out_data", {32'h0, bif0.out_data}, 64'h101);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        idle(3);

        // clear beats a same-cycle write
        clr = 1'b1;
        write(2'd2, 7'h05, 32'h5555_5555, 1'b1);
        clr = 1'b0;
        lookup(7'h05, 32'h55, 32'h55, 1'b0, 2'd0, 1'b1);
        lookup(7'h33, 32'h66, 32'h66, 1'b0, 2'd0, 1'b1);
        idle(2);

        // mid-operation reset
        write(2'd0, 7'h6F, 32'hC, 1'b1);
        lookup(7'h6F, 32'h0, 32'hC, 1'b1, 2'd0, 1'b1);
        idle(2);
        out_ready = 1'b0;
        lookup(7'h6F, 32'h0, 32'hC, 1'b1, 2'd0, 1'b0);
        @(negedge clk);
        chk("mr_held_valid", {63'h0, bif0.out_valid}, 64'h1);
        chk("mr_held_data",  {32'h0, bif0.out_data},  64'hC);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mr_out_valid", {63'h0, bif0.out_valid}, 64'h0);
        chk("mr_in_ready",  {63'h0, bif0.in_ready},  64'h1);
        chk("mr_out_data",  {32'h0, bif0.out_data},  64'h0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        lookup(7'h6F, 32'h77, 32'h77, 1'b0, 2'd0, 1'b1);
        idle(3);

        chk("q0_drained", 64'(q0.size()), 64'h0);
        chk("q1_drained", 64'(q1.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_key_table.md
# mux_key_table

Programmable key-match lookup table with a registered, handshaked result path. It generalises the combinational key mux: entries are written at run time, each carries a valid bit, multiple hits resolve by priority, and misses return a per-instance default. It is intended for NPC decode and CSR-select paths where the key-to-data mapping must be rewritten without resynthesis and the result must be pipelined.

## Interface
- `NR_KEY`, 4: number of table entries, ≥1.
- `KEY_LEN`, 7: key width in bits.
- `DATA_LEN`, 32: data width in bits.
- `HAS_DEFAULT`, 1: 1 = a miss returns `default_out`; 0 = a miss returns all zeros.
- `clk` input 1: single clock. Everything is sampled on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `wr_en` input 1: write one entry this cycle.
- `wr_idx` input $clog2(NR_KEY) (min 1): entry index to write.
- `wr_key` input KEY_LEN: key to store.
- `wr_data` input DATA_LEN: data to store.
- `wr_valid` input 1: valid bit to store. 0 invalidates the entry.
- `clr` input 1: invalidate all entries.
- `in_valid` input 1: lookup request present.
- `in_ready` output 1: table can accept a lookup.
- `in_key` input KEY_LEN: key to look up.
- `default_out` input DATA_LEN: miss value, sampled in the accept cycle.
- `out_valid` output 1: result held in the output register.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output DATA_LEN: lookup result.
- `out_hit` output 1: 1 = at least one valid entry matched.
- `out_idx` output $clog2(NR_KEY) (min 1): index of the winning entry. 0 on a miss.

## Operation
- Storage: `NR_KEY` entries, each holding {valid, key, data}.
- Match: an entry matches when it is valid and its key equals `in_key`. The lowest matching index wins.
- Result:
  - Hit: the winner's data, `out_hit`=1, `out_idx`=winner.
  - Miss: `default_out` (or 0 when `HAS_DEFAULT`=0), `out_hit`=0, `out_idx`=0.
- Write port: when `wr_en`=1, entry `wr_idx` takes {`wr_valid`, `wr_key`, `wr_data`}.
  - `wr_idx` ≥ `NR_KEY` is ignored; no entry changes.
- Clear: `clr`=1 zeroes every valid bit. Keys and data may be left unchanged.
  - `clr` and `wr_en` in the same cycle: `clr` wins. No entry is valid afterwards.
- Lookup handshake: a request is accepted on a cycle with `in_valid`=1 and `in_ready`=1.
  - The result is computed from the table contents *before* that edge's write or clear (read-before-write).
  - The result is loaded into the output register.
- Output register: single entry.
  - `in_ready` = !`out_valid` || `out_ready`. This is combinational, so full throughput is sustained under continuous `out_ready`.
  - `out_valid` is set on accept.
  - `out_valid` clears on a cycle with `out_ready`=1 and no new accept.
  - `out_data`, `out_hit` and `out_idx` are stable while `out_valid`=1 and `out_ready`=0.
- Reset:
  - All valid bits = 0.
  - `out_valid`=0, `out_data`=0, `out_hit`=0, `out_idx`=0.
  - `in_ready`=1 from the first cycle after reset.
  - A lookup in flight is discarded. Writes in the reset cycle are ignored.

## Timing
- Lookup latency: 1 cycle. Accept at edge N; `out_*` is valid after edge N, visible in cycle N+1.
- Write-to-lookup visibility: a write at edge N affects lookups accepted at edge N+1 or later.
- Throughput: 1 lookup per cycle while `out_ready`=1.
- Backpressure:
  - With `out_valid`=1 and `out_ready`=0, `in_ready`=0 and the output holds.
  - The upstream keeps `in_key` and `default_out` stable until accept.
- No combinational path from `in_key` or `wr_*` to any output. `in_ready` depends only on `out_valid` and `out_ready`.
- Match logic is one level: an equality compare per entry plus a priority encoder. `NR_KEY` ≤ 32 must close timing at the NPC target clock.

## Test plan
- **Reset and empty table:** after `rst`, NR_KEY=4, KEY_LEN=7, DATA_LEN=32, HAS_DEFAULT=1. Look up key 7'h13 with `default_out`=32'hDEAD_BEEF → next cycle `out_valid`=1, `out_data`=32'hDEAD_BEEF, `out_hit`=0, `out_idx`=0.
- **Priority:** write entry 1 = {1, 7'h33, 32'h1111_1111} and entry 3 = {1, 7'h33, 32'h3333_3333}. Look up 7'h33 → `out_data`=32'h1111_1111, `out_idx`=1. Invalidate entry 1, look up again → 32'h3333_3333, `out_idx`=3.
- **Read-before-write:** with entry 0 = {1, 7'h6F, 32'hA}, in the same cycle accept a lookup of 7'h6F and write entry 0 = {1, 7'h6F, 32'hB} → result is 32'hA. The next lookup returns 32'hB.
- **Backpressure:** stream keys 7'h01, 7'h02, 7'h03, holding `out_ready`=0 for 3 cycles after the first accept → `in_ready`=0 and `out_data` holds the 7'h01 result. Release → three results in order, no loss or duplication.
- **Clear vs. write:** `clr`=1 and `wr_en`=1 (idx 2, key 7'h05, valid 1) in the same cycle. Then look up 7'h05 with HAS_DEFAULT=0 → `out_hit`=0, `out_data`=0.
- **Mid-operation reset:** pulse `rst` while `out_valid`=1 and `out_ready`=0 → next cycle `out_valid`=0, `in_ready`=1. A prior valid key now misses.
